twiddle_sequencer: RTL

TWIDDLE_SEQUENCER -- requirements
Module: twiddle_sequencer

---
 rtl/twiddle_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/twiddle_sequencer.sv
// Radix-2 DIT butterfly schedule generator: walks stages and butterflies,
// fetches the twiddle from an external combinational ROM and issues valid/ready descriptors.
module twiddle_sequencer #(
  parameter int unsigned MAX_N      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_N),
  parameter int unsigned PRECISION  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_points,
  output logic [ADDR_WIDTH-1:0] rom_k,
  output logic [ADDR_WIDTH:0]   rom_n,
  input  logic [15:0]           rom_twiddle,
  output logic                  bf_valid,
  input  logic                  bf_ready,
  output logic [ADDR_WIDTH-1:0] bf_addr_a,
  output logic [ADDR_WIDTH-1:0] bf_addr_b,
  output logic [15:0]           bf_twiddle,
  output logic [2:0]            bf_stage,
  output logic                  bf_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned NW = ADDR_WIDTH + 1;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [SW-1:0]         log2n_q, log2n_d;
  logic [SW-1:0]         s_q, s_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [15:0]           tw_q, tw_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] half_c, pos_c, grp_c, addr_a_c, j_end_c;
  logic [SW-1:0]         s_end_c, lg_c;
  logic                  is_last_c, legal_c;
  logic [15:0]           tw_pack_c;

  // Both encodings arrive from the ROM already packed into 16 bits.
  if (PRECISION == 0) begin : g_fp4
    assign tw_pack_c = rom_twiddle;
  end else begin : g_fp8
    assign tw_pack_c = rom_twiddle;
  end

  // Butterfly geometry for the current (s, j).
  always_comb begin
    half_c    = ADDR_WIDTH'(1) << s_q;
    pos_c     = j_q & (half_c - ADDR_WIDTH'(1));
    grp_c     = j_q >> s_q;
    addr_a_c  = (grp_c << (s_q + SW'(1))) | pos_c;
    j_end_c   = ADDR_WIDTH'(n_q >> 1) - ADDR_WIDTH'(1);
    s_end_c   = log2n_q - SW'(1);
    is_last_c = (s_q == s_end_c) && (j_q == j_end_c);
  end

  // Size check: power of two between 2 and MAX_N.
  always_comb begin
    legal_c = 1'b0;
    lg_c    = '0;
    for (int i = 1; i < int'(NW); i++) begin
      if ((n_points == (NW'(1) << i)) && ((NW'(1) << i) <= NW'(MAX_N))) begin
        legal_c = 1'b1;
        lg_c    = SW'(i);
      end
    end
  end

  assign rom_k = (state_q == S_IDLE) ? '0 : (pos_c << (s_end_c - s_q));
  assign rom_n = n_q;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    log2n_d  = log2n_q;
    s_d      = s_q;
    j_d      = j_q;
    valid_d  = valid_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_d     = tw_q;
    stage_d  = stage_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal_c) begin
            state_d = S_RUN;
            n_d     = n_points;
            log2n_d = lg_c;
            s_d     = '0;
            j_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!valid_q || bf_ready) begin
          valid_d  = 1'b1;
          addr_a_d = addr_a_c;
          addr_b_d = addr_a_c + half_c;
          tw_d     = tw_pack_c;
          stage_d  = s_q;
          last_d   = is_last_c;
          if (is_last_c) begin
            state_d = S_FLUSH;
          end else if (j_q == j_end_c) begin
            j_d = '0;
            s_d = s_q + SW'(1);
          end else begin
            j_d = j_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_FLUSH: begin
        if (bf_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      log2n_q  <= '0;
      s_q      <= '0;
      j_q      <= '0;
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      log2n_q  <= log2n_d;
      s_q      <= s_d;
      j_q      <= j_d;
      valid_q  <= valid_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      stage_q  <= stage_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bf_valid   = valid_q;
  assign bf_addr_a  = addr_a_q;
  assign bf_addr_b  = addr_b_q;
  assign bf_twiddle = tw_q;
  assign bf_stage   = stage_q;
  assign bf_last    = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
